// File: rtl/calc_pkg.sv
// Shared types and constants for the 8-bit calculator sequencer.
package calc_pkg;

    localparam int unsigned CALC_W    = 8;
    localparam int unsigned CALC_ITER = 8;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic [CALC_W-1:0] lo;
        logic [CALC_W-1:0] hi;
        logic              flag;
    } calc_rsp_t;

endpackage

// File: rtl/calc_if.sv
// Request/response handshake bundle between the operator front end and the sequencer.
interface calc_if;
    import calc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    op_e               op;
    logic [CALC_W-1:0] a;
    logic [CALC_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [CALC_W-1:0] res_lo;
    logic [CALC_W-1:0] res_hi;
    logic              flag;
    logic              busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, flag, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res_lo, res_hi, flag, busy
    );

endinterface

// File: rtl/adder_8.sv
// Shared 8-bit ripple adder with carry in/out.
module adder_8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = 9'(x) + 9'(y) + 9'(cin);

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle add/sub/mul/div controller built around a single shared adder_8.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    calc_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CALC_W-1:0] phi_q, phi_d;
    logic [CALC_W-1:0] plo_q, plo_d;
    logic [CALC_W-1:0] b_q, b_d;
    calc_rsp_t         rsp_q, rsp_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [CALC_W-1:0] add_x, add_y, add_sum;
    logic              add_cin, add_cout;
    logic [CALC_W:0]   rem_ext;
    logic              rem_ge;
    logic              last_iter;

    adder_8 u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand selection; the shifted remainder needs a 9th bit that the adder cannot see.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        rem_ext = {phi_q, plo_q[CALC_W-1]};
        case (state_q)
            IDLE: begin
                add_x = bus.a;
                if (bus.op == OP_SUB) begin
                    add_y   = ~bus.b;
                    add_cin = 1'b1;
                end else begin
                    add_y = bus.b;
                end
            end
            MUL: begin
                add_x = phi_q;
                add_y = plo_q[0] ? b_q : '0;
            end
            DIV: begin
                add_x   = rem_ext[CALC_W-1:0];
                add_y   = ~b_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign rem_ge    = rem_ext[CALC_W] | add_cout;
    assign last_iter = (cnt_q == CNT_W'(CALC_ITER - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        b_d     = b_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_d = '0;
                    phi_d = '0;
                    plo_d = bus.a;
                    b_d   = bus.b;
                    case (bus.op)
                        OP_ADD: begin
                            rsp_d   = '{lo: add_sum, hi: '0, flag: add_cout};
                            state_d = DONE;
                        end
                        OP_SUB: begin
                            rsp_d   = '{lo: add_sum, hi: '0, flag: ~add_cout};
                            state_d = DONE;
                        end
                        OP_MUL: state_d = MUL;
                        default: begin
                            if (bus.b == '0) begin
                                rsp_d   = '{lo: '1, hi: bus.a, flag: 1'b1};
                                state_d = DONE;
                            end else begin
                                state_d = DIV;
                            end
                        end
                    endcase
                end
            end
            MUL: begin
                phi_d = {add_cout, add_sum[CALC_W-1:1]};
                plo_d = {add_sum[0], plo_q[CALC_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    rsp_d   = '{lo: plo_d, hi: phi_d, flag: |phi_d};
                    state_d = DONE;
                end
            end
            DIV: begin
                plo_d = {plo_q[CALC_W-2:0], rem_ge};
                phi_d = rem_ge ? add_sum : rem_ext[CALC_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    rsp_d   = '{lo: plo_d, hi: phi_d, flag: 1'b0};
                    state_d = DONE;
                end
            end
            default: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == MUL) || (state_d == DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phi_q       <= '0;
            plo_q       <= '0;
            b_q         <= '0;
            rsp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phi_q       <= phi_d;
            plo_q       <= plo_d;
            b_q         <= b_d;
            rsp_q       <= rsp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.res_lo    = rsp_q.lo;
    assign bus.res_hi    = rsp_q.hi;
    assign bus.flag      = rsp_q.flag;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed corner cases plus random operations vs an arithmetic model.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    calc_if bus();

    calc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Expected result from plain arithmetic.
    task automatic ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] lo, output logic [7:0] hi, output logic f,
                             output int lat);
        int s;
        lat = 1;
        hi  = 8'h00;
        case (op)
            2'b00: begin s = int'(a) + int'(b); lo = 8'(s); f = (s > 255); end
            2'b01: begin s = int'(a) - int'(b); lo = 8'(s); f = (a < b); end
            2'b10: begin s = int'(a) * int'(b); lo = 8'(s); hi = 8'(s / 256); f = (s > 255); lat = 9; end
            default: begin
                if (b == 8'd0) begin lo = 8'hFF; hi = a; f = 1'b1; end
                else begin lo = a / b; hi = a % b; f = 1'b0; lat = 9; end
            end
        endcase
    endtask

    // Drives one transaction, optionally holds the response under backpressure, then consumes it.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, output logic [7:0] lo, output logic [7:0] hi,
                          output logic f, output int lat, output int side_err);
        int k;
        k = 0;
        side_err = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        bus.op = op_e'(op); bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = op_e'(2'($urandom_range(3))); bus.a = 8'($urandom); bus.b = 8'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) side_err++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        lo = bus.res_lo; hi = bus.res_hi; f = bus.flag;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.op = op_e'(2'($urandom_range(3))); bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(posedge clk); #1;
            if ({bus.res_lo, bus.res_hi, bus.flag, bus.out_valid, bus.in_ready, bus.busy}
                !== {lo, hi, f, 3'b100}) side_err++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus.res_lo, bus.res_hi, bus.flag, bus.out_valid, bus.busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0", {bus.res_lo, bus.res_hi, bus.flag, bus.out_valid, bus.busy});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_add();
        logic [7:0] lo, hi; logic f; int lat, se;
        run_op(2'b00, 8'd200, 8'd100, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f} !== {8'h2C, 8'h00, 1'b1}) begin n_fail++; $display("FAIL add_ovf got %h exp %h", {lo, hi, f}, {8'h2C, 8'h00, 1'b1}); end
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", lat); end
    endtask

    task automatic test_sub();
        logic [7:0] lo, hi; logic f; int lat, se;
        run_op(2'b01, 8'd5, 8'd7, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'hFE, 8'h00, 1'b1, 32'd1}) begin n_fail++; $display("FAIL sub_borrow got %h/%h/%b lat %0d exp fe/00/1 lat 1", lo, hi, f, lat); end
        run_op(2'b01, 8'd7, 8'd5, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'h02, 8'h00, 1'b0, 32'd1}) begin n_fail++; $display("FAIL sub_noborrow got %h/%h/%b lat %0d exp 02/00/0 lat 1", lo, hi, f, lat); end
    endtask

    task automatic test_mul();
        logic [7:0] lo, hi; logic f; int lat, se;
        run_op(2'b10, 8'hFF, 8'hFF, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({hi, lo, f} !== {8'hFE, 8'h01, 1'b1}) begin n_fail++; $display("FAIL mul_max got %h exp %h", {hi, lo, f}, {8'hFE, 8'h01, 1'b1}); end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL mul_latency got %0d exp 9", lat); end
        n_checks++;
        if (se !== 0) begin n_fail++; $display("FAIL mul_busy_ready got %0d bad cycles exp 0", se); end
        run_op(2'b10, 8'd12, 8'd10, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({hi, lo, f, lat} !== {16'h0078, 1'b0, 32'd9}) begin n_fail++; $display("FAIL mul_small got %h%h/%b lat %0d exp 0078/0 lat 9", hi, lo, f, lat); end
    endtask

    task automatic test_div();
        logic [7:0] lo, hi; logic f; int lat, se;
        run_op(2'b11, 8'd200, 8'd7, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'd28, 8'd4, 1'b0, 32'd9}) begin n_fail++; $display("FAIL div_200_7 got %0d r %0d f %b lat %0d exp 28 r 4 f 0 lat 9", lo, hi, f, lat); end
        n_checks++;
        if (se !== 0) begin n_fail++; $display("FAIL div_busy_ready got %0d bad cycles exp 0", se); end
        run_op(2'b11, 8'd13, 8'd0, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'hFF, 8'h0D, 1'b1, 32'd1}) begin n_fail++; $display("FAIL div_by_zero got %h/%h/%b lat %0d exp ff/0d/1 lat 1", lo, hi, f, lat); end
        run_op(2'b11, 8'd5, 8'd9, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'd0, 8'd5, 1'b0, 32'd9}) begin n_fail++; $display("FAIL div_small got %0d r %0d f %b lat %0d exp 0 r 5 f 0 lat 9", lo, hi, f, lat); end
    endtask

    task automatic test_backpressure();
        logic [7:0] lo, hi, elo, ehi; logic f, ef; int lat, elat, se;
        ref_model(2'b10, 8'h5A, 8'h3C, elo, ehi, ef, elat);
        run_op(2'b10, 8'h5A, 8'h3C, 5, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f} !== {elo, ehi, ef}) begin n_fail++; $display("FAIL bp_result got %h exp %h", {lo, hi, f}, {elo, ehi, ef}); end
        n_checks++;
        if (se !== 0) begin n_fail++; $display("FAIL bp_stable got %0d bad cycles exp 0", se); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got %b exp 1", bus.in_ready); end
        run_op(2'b00, 8'd10, 8'd20, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'd30, 8'd0, 1'b0, 32'd1}) begin n_fail++; $display("FAIL bp_next_op got %0d/%0d/%b lat %0d exp 30/0/0 lat 1", lo, hi, f, lat); end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] lo, hi; logic f; int lat, se;
        run_op(2'b00, 8'd1, 8'd2, 0, lo, hi, f, lat, se);
        bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midmul_busy got %b exp 1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.res_lo, bus.res_hi, bus.flag, bus.out_valid, bus.busy} !== 19'h0) begin
            n_fail++;
            $display("FAIL midmul_async_reset got %h exp 0", {bus.res_lo, bus.res_hi, bus.flag, bus.out_valid, bus.busy});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL midmul_after_release got %b exp 01", {bus.out_valid, bus.in_ready}); end
        run_op(2'b10, 8'd3, 8'd4, 0, lo, hi, f, lat, se);
        n_checks++;
        if ({lo, hi, f, lat} !== {8'd12, 8'd0, 1'b0, 32'd9}) begin n_fail++; $display("FAIL midmul_next got %0d/%0d/%b lat %0d exp 12/0/0 lat 9", lo, hi, f, lat); end
    endtask

    task automatic test_random();
        logic [7:0] lo, hi, elo, ehi, a, b; logic [1:0] op; logic f, ef; int lat, elat, se;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(3));
            a  = 8'($urandom);
            b  = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            ref_model(op, a, b, elo, ehi, ef, elat);
            run_op(op, a, b, int'($urandom_range(2)), lo, hi, f, lat, se);
            n_checks++;
            if ({lo, hi, f, lat, se} !== {elo, ehi, ef, elat, 32'd0}) begin
                n_fail++;
                $display("FAIL rand[%0d] op %0d a %0d b %0d got %h/%h/%b lat %0d se %0d exp %h/%h/%b lat %0d",
                         i, op, a, b, lo, hi, f, lat, se, elo, ehi, ef, elat);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
